fetch_decode_ff: RTL and testbench

Pipeline register between the fetch stage and the decode stage, with a one-entry skid buffer. It captures each fetched instruction and its incremented PC, holds them while decode is stalled, and drops them on a flush. It also produces the valid/NOP qualification that decode passes to the decode-execute register. Instruction-memory returns that arrive in the cycle a stall begins are parked in the skid entry, so no fetched instruction is lost.

---
 rtl/fetch_decode_ff.sv | 80 ++++++++
 tb/tb_fetch_decode_ff.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_ff.sv
// Fetch/decode pipeline register with a one-entry skid buffer.
// It holds on stall, clears on flush, and produces the valid/NOP qualification for decode.
module fetch_decode_ff #(
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inst_FD_in,
  input  logic [15:0] inc_PC_FD_in,
  input  logic        fetch_valid,
  input  logic        stall,
  input  logic        flush,
  output logic        fetch_ready,
  output logic [15:0] inst_FD_out,
  output logic [15:0] inc_PC_FD_out,
  output logic        valid_FD_out,
  output logic        insert_NOP_out
);

  logic [15:0] r_inst;
  logic [15:0] r_pc;
  logic        r_valid;
  logic [15:0] r_skid_inst;
  logic [15:0] r_skid_pc;
  logic        r_skid_valid;
  logic        r_fetch_ready;

  logic w_accept;

  // A fetch presented while not ready is ignored outright.
  assign w_accept = fetch_valid & r_fetch_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst        <= NOP_INST;
      r_pc          <= 16'h0000;
      r_valid       <= 1'b0;
      r_skid_inst   <= NOP_INST;
      r_skid_pc     <= 16'h0000;
      r_skid_valid  <= 1'b0;
      r_fetch_ready <= 1'b1;
    end else if (flush) begin
      // Everything held or arriving now is on the wrong path.
      r_inst        <= NOP_INST;
      r_pc          <= 16'h0000;
      r_valid       <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_fetch_ready <= 1'b1;
    end else if (stall) begin
      if (w_accept) begin
        r_skid_inst   <= inst_FD_in;
        r_skid_pc     <= inc_PC_FD_in;
        r_skid_valid  <= 1'b1;
        r_fetch_ready <= 1'b0;
      end
    end else if (r_skid_valid) begin
      // Drain the parked instruction; fetch_ready is low so nothing else can arrive.
      r_inst        <= r_skid_inst;
      r_pc          <= r_skid_pc;
      r_valid       <= 1'b1;
      r_skid_valid  <= 1'b0;
      r_fetch_ready <= 1'b1;
    end else if (w_accept) begin
      r_inst  <= inst_FD_in;
      r_pc    <= inc_PC_FD_in;
      r_valid <= 1'b1;
    end else begin
      r_inst  <= NOP_INST;
      r_pc    <= 16'h0000;
      r_valid <= 1'b0;
    end
  end

  assign fetch_ready    = r_fetch_ready;
  assign inst_FD_out    = r_inst;
  assign inc_PC_FD_out  = r_pc;
  assign valid_FD_out   = r_valid;
  assign insert_NOP_out = stall | ~r_valid;

endmodule

// File: tb/tb_fetch_decode_ff.sv
// Scoreboard bench for fetch_decode_ff: stimulus pushes expected survivors,
// a negedge monitor pops one whenever decode consumes a valid instruction.
module tb_fetch_decode_ff;

  logic        clk;
  logic        rst;
  logic [15:0] inst_FD_in;
  logic [15:0] inc_PC_FD_in;
  logic        fetch_valid;
  logic        stall;
  logic        flush;
  logic        fetch_ready;
  logic [15:0] inst_FD_out;
  logic [15:0] inc_PC_FD_out;
  logic        valid_FD_out;
  logic        insert_NOP_out;

  typedef struct {
    logic [15:0] inst;
    logic [15:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  fetch_decode_ff #(.NOP_INST(16'h0800)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_FD_in    (inst_FD_in),
    .inc_PC_FD_in  (inc_PC_FD_in),
    .fetch_valid   (fetch_valid),
    .stall         (stall),
    .flush         (flush),
    .fetch_ready   (fetch_ready),
    .inst_FD_out   (inst_FD_out),
    .inc_PC_FD_out (inc_PC_FD_out),
    .valid_FD_out  (valid_FD_out),
    .insert_NOP_out(insert_NOP_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s: got %h", name, act);
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] inst, input logic [15:0] pc);
    exp_t e;
    e.inst = inst;
    e.pc   = pc;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic fv, input logic [15:0] inst, input logic [15:0] pc,
                       input logic st, input logic fl);
    fetch_valid  = fv;
    inst_FD_in   = inst;
    inc_PC_FD_in = pc;
    stall        = st;
    flush        = fl;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_inst"}, {16'h0, inst_FD_out}, 32'h0800);
    chk({tag, "_pc"}, {16'h0, inc_PC_FD_out}, 32'h0000);
    chk({tag, "_valid"}, {31'h0, valid_FD_out}, 32'h0);
  endtask

  // Monitor: an instruction is consumed at the coming edge when valid, unstalled, unflushed.
  always @(negedge clk) begin
    if (!rst && valid_FD_out && !stall && !flush) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got inst %h pc %h expected none", inst_FD_out, inc_PC_FD_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_inst", {16'h0, inst_FD_out}, {16'h0, e.inst});
        chk("sb_pc", {16'h0, inc_PC_FD_out}, {16'h0, e.pc});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    chk_empty("reset");
    chk("reset_ready", {31'h0, fetch_ready}, 32'h1);
    chk("reset_insnop", {31'h0, insert_NOP_out}, 32'h1);
    rst = 1'b0;
    tick();

    // Single accept, one-cycle latency, then idle bubble
    drive(1'b1, 16'h1234, 16'h0002, 1'b0, 1'b0);
    push(16'h1234, 16'h0002);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("acc_inst", {16'h0, inst_FD_out}, 32'h1234);
    chk("acc_pc", {16'h0, inc_PC_FD_out}, 32'h0002);
    chk("acc_valid", {31'h0, valid_FD_out}, 32'h1);
    chk("acc_insnop", {31'h0, insert_NOP_out}, 32'h0);
    tick();
    chk_empty("idle");

    // Stall with a same-cycle accept parks the new instruction in the skid
    drive(1'b1, 16'hA001, 16'h0002, 1'b0, 1'b0);
    push(16'hA001, 16'h0002);
    tick();
    drive(1'b1, 16'hB002, 16'h0004, 1'b1, 1'b0);
    push(16'hB002, 16'h0004);
    tick();
    drive(1'b1, 16'hDEAD, 16'h0006, 1'b1, 1'b0);
    chk("stall_inst", {16'h0, inst_FD_out}, 32'hA001);
    chk("stall_ready", {31'h0, fetch_ready}, 32'h0);
    chk("stall_insnop", {31'h0, insert_NOP_out}, 32'h1);
    tick();
    chk("stall2_inst", {16'h0, inst_FD_out}, 32'hA001);
    chk("stall2_ready", {31'h0, fetch_ready}, 32'h0);
    // Release stall; DEAD is still offered while not ready and must be ignored
    drive(1'b1, 16'hDEAD, 16'h0006, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("drain_inst", {16'h0, inst_FD_out}, 32'hB002);
    chk("drain_pc", {16'h0, inc_PC_FD_out}, 32'h0004);
    chk("drain_valid", {31'h0, valid_FD_out}, 32'h1);
    chk("drain_ready", {31'h0, fetch_ready}, 32'h1);
    tick();
    chk_empty("after_drain");

    // Flush with stall while the skid is full: nothing survives
    drive(1'b1, 16'hC003, 16'h0008, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'hD004, 16'h000A, 1'b1, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    chk("skidfull_ready", {31'h0, fetch_ready}, 32'h0);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk_empty("flush");
    chk("flush_ready", {31'h0, fetch_ready}, 32'h1);
    chk("flush_insnop", {31'h0, insert_NOP_out}, 32'h1);
    tick();
    chk_empty("post_flush");

    // An accept in the flush cycle is dropped
    drive(1'b1, 16'hE005, 16'h000C, 1'b0, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk_empty("flush_accept");

    // Back-to-back accepts with no stall
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 16'(i), 16'(2 * i), 1'b0, 1'b0);
      push(16'(i), 16'(2 * i));
      tick();
      chk("b2b_inst", {16'h0, inst_FD_out}, i);
      chk("b2b_valid", {31'h0, valid_FD_out}, 32'h1);
    end
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    chk_empty("b2b_end");

    // Asynchronous reset while stalled with the skid full
    drive(1'b1, 16'h1111, 16'h0010, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h2222, 16'h0012, 1'b1, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    chk("pre_rst_ready", {31'h0, fetch_ready}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk_empty("async_rst");
    chk("async_rst_ready", {31'h0, fetch_ready}, 32'h1);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    chk_empty("after_rst");

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
